// File: rtl/pcileech_ft601_responder_if.sv
// FT601 pad bundle plus the host-side word streams of the FT601 responder.
// Streams use valid/ready: a word moves on a rising clk edge where both
// valid and ready are high; valid must not depend on ready.
interface pcileech_ft601_responder_if;
  logic        ft601_rst_n;
  logic [31:0] ft601_data_i;
  logic [31:0] ft601_data_o;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be_i;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_wr_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic [31:0] host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [31:0] host_tx_data;
  logic [3:0]  host_tx_be;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic        stat_clr;
  logic        stat_ovf;
  logic        stat_udf;
  logic        stat_conflict;

  // Responder side (the modelled chip).
  modport slave (
    input  ft601_rst_n, ft601_data_i, ft601_be_i, ft601_wr_n, ft601_rd_n, ft601_oe_n,
    input  host_rx_data, host_rx_valid, host_tx_ready, stat_clr,
    output ft601_data_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
    output host_rx_ready, host_tx_data, host_tx_be, host_tx_valid,
    output stat_ovf, stat_udf, stat_conflict
  );

  // FPGA pads plus host agent driving the responder.
  modport master (
    output ft601_rst_n, ft601_data_i, ft601_be_i, ft601_wr_n, ft601_rd_n, ft601_oe_n,
    output host_rx_data, host_rx_valid, host_tx_ready, stat_clr,
    input  ft601_data_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
    input  host_rx_ready, host_tx_data, host_tx_be, host_tx_valid,
    input  stat_ovf, stat_udf, stat_conflict
  );
endinterface

// File: rtl/pcileech_ft601_responder.sv
// Device-side FT601 245-synchronous FIFO model: host words are served to the
// FPGA as read data, FPGA writes are captured and returned to the host.
module pcileech_ft601_responder #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pcileech_ft601_responder_if.slave bus
);
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0]   RX_FULL    = RX_DEPTH[RX_DEPTH_LOG2:0];
  localparam logic [TX_DEPTH_LOG2:0]   TX_FULL    = TX_DEPTH[TX_DEPTH_LOG2:0];
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE = 1;
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE = 1;
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE = 1;
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE = 1;

  logic [31:0]              rx_mem [RX_DEPTH];
  logic [35:0]              tx_mem [TX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_DEPTH_LOG2:0]   rx_count, rx_count_next;
  logic [TX_DEPTH_LOG2:0]   tx_count, tx_count_next;
  logic alive_q, rxf_n_q, txe_n_q;
  logic ovf_q, udf_q, conflict_q;
  logic rd_req, wr_req, chip_run;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic udf_evt, ovf_evt, conflict_evt;

  // Request decode, FIFO handshakes and protocol-violation detection.
  always_comb begin
    chip_run     = bus.ft601_rst_n;
    rd_req       = ~bus.ft601_rd_n & ~bus.ft601_oe_n;
    wr_req       = ~bus.ft601_wr_n;
    rx_empty     = (rx_count == '0);
    rx_full      = (rx_count == RX_FULL);
    tx_empty     = (tx_count == '0);
    tx_full      = (tx_count == TX_FULL);
    rx_push      = bus.host_rx_valid & alive_q & chip_run & ~rx_full;
    rx_pop       = rd_req & ~rx_empty & chip_run;
    // A write with OE low collides with the chip driving the bus: dropped.
    tx_push      = wr_req & bus.ft601_oe_n & ~tx_full & chip_run;
    tx_pop       = ~tx_empty & bus.host_tx_ready & chip_run;
    udf_evt      = rd_req & rx_empty & chip_run;
    ovf_evt      = wr_req & tx_full & chip_run;
    conflict_evt = wr_req & ~bus.ft601_oe_n & chip_run;
  end

  // Next-state occupancy; the chip reset flushes both FIFOs.
  always_comb begin
    rx_count_next = rx_count;
    tx_count_next = tx_count;
    if (!chip_run) begin
      rx_count_next = '0;
      tx_count_next = '0;
    end else begin
      if (rx_push && !rx_pop) rx_count_next = rx_count + RX_CNT_ONE;
      else if (rx_pop && !rx_push) rx_count_next = rx_count - RX_CNT_ONE;
      if (tx_push && !tx_pop) tx_count_next = tx_count + TX_CNT_ONE;
      else if (tx_pop && !tx_push) tx_count_next = tx_count - TX_CNT_ONE;
    end
  end

  // Pointers, counts, registered bus flags and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      rx_count   <= '0;
      tx_count   <= '0;
      alive_q    <= 1'b0;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      alive_q  <= 1'b1;
      rx_count <= rx_count_next;
      tx_count <= tx_count_next;
      rxf_n_q  <= (rx_count_next == '0) | ~chip_run;
      txe_n_q  <= (tx_count_next == TX_FULL) | ~chip_run;
      if (!chip_run) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
      end
      // A violation in the same cycle as a clear leaves the flag set.
      ovf_q      <= (ovf_q & ~bus.stat_clr) | ovf_evt;
      udf_q      <= (udf_q & ~bus.stat_clr) | udf_evt;
      conflict_q <= (conflict_q & ~bus.stat_clr) | conflict_evt;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by count.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.host_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= {bus.ft601_be_i, bus.ft601_data_i};
  end

  assign bus.ft601_data_o  = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
  assign bus.ft601_data_oe = ~bus.ft601_oe_n & rst_n;
  assign bus.ft601_rxf_n   = rxf_n_q;
  assign bus.ft601_txe_n   = txe_n_q;
  assign bus.host_rx_ready = alive_q & chip_run & ~rx_full;
  assign bus.host_tx_valid = ~tx_empty;
  assign bus.host_tx_data  = tx_empty ? 32'h0 : tx_mem[tx_rd_ptr][31:0];
  assign bus.host_tx_be    = tx_empty ? 4'h0 : tx_mem[tx_rd_ptr][35:32];
  assign bus.stat_ovf      = ovf_q;
  assign bus.stat_udf      = udf_q;
  assign bus.stat_conflict = conflict_q;
endmodule
